// File: rtl/alu_master_pkg.sv
// Shared types, constants and helpers for the ALU request master.
package alu_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } alu_mst_state_e;

    localparam int unsigned CMD_MUL_INC = 9;
    localparam int unsigned CMD_MUL_SHL = 10;

    localparam int unsigned FLG_ERR   = 0;
    localparam int unsigned FLG_E     = 1;
    localparam int unsigned FLG_L     = 2;
    localparam int unsigned FLG_G     = 3;
    localparam int unsigned FLG_COUT  = 4;
    localparam int unsigned FLG_OFLOW = 5;
    localparam int unsigned FLG_W     = 6;

    typedef struct packed {
        logic oflow;
        logic cout;
        logic g;
        logic l;
        logic e;
        logic err;
    } alu_flags_t;

    // Multiply commands only exist in arithmetic mode and take the longer latency.
    function automatic int unsigned cmd_latency(input logic        mode,
                                                input logic [31:0] cmd,
                                                input int unsigned lat,
                                                input int unsigned mul_lat);
        if (mode && ((cmd == 32'(CMD_MUL_INC)) || (cmd == 32'(CMD_MUL_SHL))))
            return mul_lat;
        return lat;
    endfunction

endpackage

// File: rtl/alu_req_master_if.sv
// Request/response channels between a request source and the ALU request master.
interface alu_req_master_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CMD_WIDTH = 4,
    parameter int unsigned TAG_WIDTH = 4
);
    import alu_master_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [WIDTH-1:0]     req_opa;
    logic [WIDTH-1:0]     req_opb;
    logic [CMD_WIDTH-1:0] req_cmd;
    logic                 req_mode;
    logic                 req_cin;
    logic [1:0]           req_inp_valid;
    logic [TAG_WIDTH-1:0] req_tag;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WIDTH:0]       rsp_res;
    logic [FLG_W-1:0]     rsp_flags;
    logic [TAG_WIDTH-1:0] rsp_tag;

    modport master (
        output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inp_valid, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_res, rsp_flags, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inp_valid, req_tag,
        output req_ready,
        output rsp_valid, rsp_res, rsp_flags, rsp_tag,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_sat_cnt.sv
// Counter with increment enable that sticks at all-ones.
module alu_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/alu_req_master.sv
// Issues one ALU operation at a time from a valid/ready request channel and
// returns the captured result and flags on a tagged valid/ready response channel.
module alu_req_master
    import alu_master_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CMD_WIDTH = 4,
    parameter int unsigned TAG_WIDTH = 4,
    parameter int unsigned LAT       = 1,
    parameter int unsigned MUL_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_req_master_if.slave      bus,
    output logic [WIDTH-1:0]     opa,
    output logic [WIDTH-1:0]     opb,
    output logic [CMD_WIDTH-1:0] cmd,
    output logic                 mode,
    output logic                 cin,
    output logic                 ce,
    output logic [1:0]           inp_valid,
    input  logic [WIDTH:0]       res,
    input  logic                 oflow,
    input  logic                 cout,
    input  logic                 g,
    input  logic                 l,
    input  logic                 e,
    input  logic                 err,
    output logic [15:0]          op_count,
    output logic [15:0]          err_count
);

    localparam int unsigned MAX_LAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    alu_mst_state_e       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [TAG_WIDTH-1:0] tag_q;
    alu_flags_t           flags_c;

    logic accept_c, issue_c, capture_c, rsp_fire_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept_c)   state_d = ST_ISSUE;
            ST_ISSUE:                 state_d = ST_WAIT;
            ST_WAIT:  if (capture_c)  state_d = ST_RESP;
            ST_RESP:  if (rsp_fire_c) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Per-state strobes that steer the output/datapath registers
    always_comb begin
        accept_c   = 1'b0;
        issue_c    = 1'b0;
        capture_c  = 1'b0;
        rsp_fire_c = 1'b0;
        unique case (state_q)
            ST_IDLE:  accept_c   = bus.req_valid && bus.req_ready;
            ST_ISSUE: issue_c    = 1'b1;
            ST_WAIT:  capture_c  = (cnt_q == CNT_W'(1));
            ST_RESP:  rsp_fire_c = bus.rsp_valid && bus.rsp_ready;
            default:  ;
        endcase
    end

    always_comb begin
        flags_c = '{oflow: oflow, cout: cout, g: g, l: l, e: e, err: err};
    end

    // ALU-side drive, latency count and response capture; ALU operands are held
    // from acceptance until the next accepted request so the core sees stable inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.req_ready <= 1'b0;
            opa           <= '0;
            opb           <= '0;
            cmd           <= '0;
            mode          <= 1'b0;
            cin           <= 1'b0;
            ce            <= 1'b0;
            inp_valid     <= 2'b00;
            cnt_q         <= '0;
            tag_q         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_res   <= '0;
            bus.rsp_flags <= '0;
            bus.rsp_tag   <= '0;
        end else begin
            bus.req_ready <= (state_d == ST_IDLE);
            if (accept_c) begin
                opa       <= bus.req_opa;
                opb       <= bus.req_opb;
                cmd       <= bus.req_cmd;
                mode      <= bus.req_mode;
                cin       <= bus.req_cin;
                inp_valid <= bus.req_inp_valid;
                ce        <= 1'b1;
                tag_q     <= bus.req_tag;
            end
            if (issue_c) begin
                ce        <= 1'b0;
                inp_valid <= 2'b00;
                cnt_q     <= CNT_W'(cmd_latency(mode, 32'(cmd), LAT, MUL_LAT));
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture_c) begin
                bus.rsp_res   <= res;
                bus.rsp_flags <= flags_c;
                bus.rsp_tag   <= tag_q;
                bus.rsp_valid <= 1'b1;
            end
            if (rsp_fire_c)
                bus.rsp_valid <= 1'b0;
        end
    end

    alu_sat_cnt #(.W(16)) u_op_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rsp_fire_c),
        .count (op_count)
    );

    alu_sat_cnt #(.W(16)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rsp_fire_c && bus.rsp_flags[FLG_ERR]),
        .count (err_count)
    );

endmodule

// File: tb/tb_alu_req_master.sv
// Scoreboard bench for alu_req_master with a small behavioural ALU attached.
module tb_alu_req_master;
    import alu_master_pkg::*;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned CMD_WIDTH = 4;
    localparam int unsigned TAG_WIDTH = 4;
    localparam int unsigned LAT       = 1;
    localparam int unsigned MUL_LAT   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_req_master_if #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

    logic [WIDTH-1:0]     opa, opb;
    logic [CMD_WIDTH-1:0] cmd;
    logic                 mode, cin, ce;
    logic [1:0]           inp_valid;
    logic [WIDTH:0]       res = '0;
    logic                 oflow = 1'b0, cout = 1'b0, g = 1'b0, l = 1'b0, e = 1'b0, err = 1'b0;
    logic [15:0]          op_count, err_count;

    alu_req_master #(
        .WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH), .TAG_WIDTH(TAG_WIDTH), .LAT(LAT), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .opa(opa), .opb(opb), .cmd(cmd), .mode(mode), .cin(cin), .ce(ce), .inp_valid(inp_valid),
        .res(res), .oflow(oflow), .cout(cout), .g(g), .l(l), .e(e), .err(err),
        .op_count(op_count), .err_count(err_count)
    );

    typedef struct packed {
        logic [WIDTH:0]       res;
        logic [5:0]           flags;
        logic [TAG_WIDTH-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   n_hs     = 0;
    int   acc_cyc  = 0;
    int   hs_cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference ALU: {res[8:0], oflow, cout, g, l, e, err}
    function automatic logic [14:0] alu_model(input logic m, input logic [3:0] c,
                                              input logic [7:0] a, input logic [7:0] b,
                                              input logic [1:0] iv);
        logic [8:0] r;
        logic       co;
        if (iv == 2'b00)
            return {9'h000, 6'b000001};
        co = 1'b0;
        if (m && c == 4'd9)
            r = 9'((9'(a) + 9'd1) * (9'(b) + 9'd1));
        else if (m && c == 4'd10)
            r = 9'(9'({a, 1'b0}) * 9'(b));
        else begin
            r  = 9'(a) + 9'(b);
            co = r[8];
        end
        return {r, 1'b0, co, (a > b), (a < b), (a == b), 1'b0};
    endfunction

    // Behavioural ALU core: result valid from the edge after ce.
    always @(posedge clk) begin
        if (ce)
            {res, oflow, cout, g, l, e, err} <= alu_model(mode, cmd, opa, opb, inp_valid);
    end

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(posedge clk) begin
        exp_t x;
        cyc = cyc + 1;
        if (rst === 1'b1 && bus.req_valid && bus.req_ready) begin
            x.tag = bus.req_tag;
            {x.res, x.flags} = alu_model(bus.req_mode, bus.req_cmd, bus.req_opa,
                                         bus.req_opb, bus.req_inp_valid);
            sb.push_back(x);
            n_acc++;
            acc_cyc = cyc;
        end
        if (rst === 1'b1 && bus.rsp_valid && bus.rsp_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'h1);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("sb_res",   32'(bus.rsp_res),   32'(x.res));
                chk("sb_flags", 32'(bus.rsp_flags), 32'(x.flags));
                chk("sb_tag",   32'(bus.rsp_tag),   32'(x.tag));
            end
            n_hs++;
            hs_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic m, input logic [3:0] c, input logic [7:0] a,
                             input logic [7:0] b, input logic [1:0] iv, input logic [3:0] t);
        bus.req_mode      = m;
        bus.req_cmd       = c;
        bus.req_opa       = a;
        bus.req_opb       = b;
        bus.req_cin       = 1'b0;
        bus.req_inp_valid = iv;
        bus.req_tag       = t;
        bus.req_valid     = 1'b1;
    endtask

    // Returns one time unit after the accepting edge (ISSUE cycle).
    task automatic issue(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] iv, input logic [3:0] t);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'h1);
        drive_req(m, c, a, b, iv, t);
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Counts edges from acceptance until rsp_valid, checking ALU drive while waiting.
    task automatic wait_rsp(input logic [7:0] a, input logic [7:0] b, output int n);
        n = 1;
        tick();
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            chk("wait_ce", 32'(ce), 32'h0);
            chk("wait_inp_valid", 32'(inp_valid), 32'h0);
            chk("wait_opa_hold", 32'(opa), 32'(a));
            chk("wait_opb_hold", 32'(opb), 32'(b));
            chk("wait_req_ready", 32'(bus.req_ready), 32'h0);
            tick();
            n++;
        end
        chk("rsp_valid_seen", 32'(bus.rsp_valid), 32'h1);
    endtask

    task automatic rsp_hs();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int acc0, hs0;
        bus.req_valid = 1'b0;
        bus.req_opa = '0; bus.req_opb = '0; bus.req_cmd = '0;
        bus.req_mode = 1'b0; bus.req_cin = 1'b0; bus.req_inp_valid = 2'b00; bus.req_tag = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_ce",        32'(ce),            32'h0);
        chk("rst_opa",       32'(opa),           32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_res",   32'(bus.rsp_res),   32'h0);
        chk("rst_op_count",  32'(op_count),      32'h0);
        rst = 1'b1;
        #1 chk("rel_req_ready_low", 32'(bus.req_ready), 32'h0);
        tick();
        chk("rel_req_ready_high", 32'(bus.req_ready), 32'h1);

        // ADD, single-cycle latency
        issue(1'b1, 4'd0, 8'h0F, 8'h01, 2'b11, 4'd3);
        chk("add_ce",        32'(ce),            32'h1);
        chk("add_inp_valid", 32'(inp_valid),     32'h3);
        chk("add_opa",       32'(opa),           32'h0F);
        chk("add_opb",       32'(opb),           32'h01);
        chk("add_req_ready", 32'(bus.req_ready), 32'h0);
        wait_rsp(8'h0F, 8'h01, n);
        chk("add_latency",   32'(n),             32'(LAT + 1));
        chk("add_rsp_res",   32'(bus.rsp_res),   32'h010);
        chk("add_rsp_tag",   32'(bus.rsp_tag),   32'h3);
        chk("add_op_count_pre", 32'(op_count),   32'h0);
        rsp_hs();
        chk("add_op_count",  32'(op_count),      32'h1);
        chk("add_rsp_drop",  32'(bus.rsp_valid), 32'h0);
        chk("add_ready_back", 32'(bus.req_ready), 32'h1);

        // MUL with backpressure
        issue(1'b1, 4'd9, 8'h03, 8'h04, 2'b11, 4'd5);
        chk("mul_ce",  32'(ce),  32'h1);
        chk("mul_cmd", 32'(cmd), 32'h9);
        wait_rsp(8'h03, 8'h04, n);
        chk("mul_latency", 32'(n),           32'(MUL_LAT + 1));
        chk("mul_rsp_res", 32'(bus.rsp_res), 32'h014);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_rsp_res",   32'(bus.rsp_res),   32'h014);
            chk("bp_rsp_tag",   32'(bus.rsp_tag),   32'h5);
            chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_ce",        32'(ce),            32'h0);
            chk("bp_op_count",  32'(op_count),      32'h1);
        end
        rsp_hs();
        chk("mul_op_count", 32'(op_count), 32'h2);

        // Reset while a multiply is in WAIT
        issue(1'b1, 4'd10, 8'h05, 8'h06, 2'b11, 4'd9);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("mrst_ce",        32'(ce),            32'h0);
        chk("mrst_opa",       32'(opa),           32'h0);
        chk("mrst_opb",       32'(opb),           32'h0);
        chk("mrst_cmd",       32'(cmd),           32'h0);
        chk("mrst_mode",      32'(mode),          32'h0);
        chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mrst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("mrst_op_count",  32'(op_count),      32'h0);
        chk("mrst_err_count", 32'(err_count),     32'h0);
        sb.delete();
        repeat (2) begin
            tick();
            chk("mrst_hold_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        end
        rst = 1'b1;
        #1 chk("mrst_rel_ready_low", 32'(bus.req_ready), 32'h0);
        tick();
        chk("mrst_rel_ready_high", 32'(bus.req_ready), 32'h1);
        repeat (3) begin
            tick();
            chk("mrst_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end

        // Request with no valid operands: ALU flags an error
        issue(1'b1, 4'd0, 8'h22, 8'h11, 2'b00, 4'd7);
        chk("err_ce",        32'(ce),        32'h1);
        chk("err_inp_valid", 32'(inp_valid), 32'h0);
        wait_rsp(8'h22, 8'h11, n);
        chk("err_latency",   32'(n),             32'(LAT + 1));
        chk("err_flags",     32'(bus.rsp_flags), 32'b000001);
        chk("err_count_pre", 32'(err_count),     32'h0);
        rsp_hs();
        chk("err_count",     32'(err_count),     32'h1);
        chk("err_op_count",  32'(op_count),      32'h1);

        // Back-to-back with rsp_ready tied high
        bus.rsp_ready = 1'b1;
        acc0 = n_acc;
        hs0  = n_hs;
        issue(1'b1, 4'd0, 8'h10, 8'h20, 2'b11, 4'd1);
        drive_req(1'b1, 4'd0, 8'h33, 8'h44, 2'b11, 4'd2);
        n = 0;
        while (n_acc < acc0 + 2 && n < 30) begin
            tick();
            n++;
        end
        bus.req_valid = 1'b0;
        chk("b2b_accepts", 32'(n_acc - acc0), 32'h2);
        chk("b2b_gap",     32'(acc_cyc - hs_cyc), 32'h1);
        n = 0;
        while (n_hs < hs0 + 2 && n < 30) begin
            tick();
            n++;
        end
        bus.rsp_ready = 1'b0;
        chk("b2b_responses", 32'(n_hs - hs0), 32'h2);
        chk("b2b_op_count",  32'(op_count),   32'h3);
        chk("b2b_err_count", 32'(err_count),  32'h1);

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_req_master.md
# alu_req_master

Initiator-side controller for the ALU port set. It accepts operation requests on a valid/ready channel and drives `opa`/`opb`/`cmd`/`mode`/`cin`/`inp_valid`/`ce` into the ALU. It waits a command-dependent latency, then captures `res` and the status flags. It returns them on a valid/ready response channel with a tag. It sits between a request source (CPU-side bridge or test harness) and the ALU core, with one operation in flight at a time.

## Interface
- Reset is asynchronous and active-low. One clock, `clk`.
- `WIDTH`, default 8: operand width. `res` is `WIDTH+1` bits.
- `CMD_WIDTH`, default 4: ALU command width.
- `TAG_WIDTH`, default 4: request tag width.
- `LAT`, default 1: ALU result latency in cycles for non-multiply commands; must be ≥1.
- `MUL_LAT`, default 2: result latency for multiply commands (`mode=1`, `cmd` 9 or 10); must be ≥1.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_opa`, `req_opb` in `WIDTH`; `req_cmd` in `CMD_WIDTH`; `req_mode`, `req_cin` in 1; `req_inp_valid` in 2; `req_tag` in `TAG_WIDTH`.
- `opa`, `opb` out `WIDTH`; `cmd` out `CMD_WIDTH`; `mode`, `cin`, `ce` out 1; `inp_valid` out 2: ALU inputs.
- `res` in `WIDTH+1`; `oflow`, `cout`, `g`, `l`, `e`, `err` in 1: ALU outputs.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_res` out `WIDTH+1`; `rsp_flags` out 6, ordered `{oflow,cout,g,l,e,err}`; `rsp_tag` out `TAG_WIDTH`.
- `op_count`, `err_count` out 16: completed-response counters. Both saturate at `16'hFFFF`.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - `req_ready=1`.
  - On `req_valid && req_ready`, register all `req_*` fields and the tag, then go to ISSUE.
- **ISSUE (exactly 1 cycle):**
  - Drive the ALU ports from the registered request, with `ce=1` and `inp_valid=req_inp_valid`.
  - Load the latency counter with `MUL_LAT` if `mode==1 && cmd∈{9,10}`, else `LAT`.
  - Go to WAIT.
- **WAIT:**
  - `ce=0`, `inp_valid=2'b00`.
  - `opa`/`opb`/`cmd`/`mode`/`cin` hold their issued values.
  - Counter decrements each cycle. In the cycle where the counter equals 1, capture `res` and the six flags into the `rsp_*` registers at the next edge, then go to RESP.
- **RESP:**
  - `rsp_valid=1`; the `rsp_*` outputs are stable until the handshake.
  - On `rsp_valid && rsp_ready`: go to IDLE, increment `op_count`, and increment `err_count` if `rsp_flags[0]`.
- Requests with `inp_valid=2'b00` are issued unchanged. Error reporting is the ALU's job via `err`.
- `req_ready` is 0 in every state except IDLE. Nothing is queued.

## Timing
- **Reset values:**
  - All ALU-side outputs, `rsp_*`, `rsp_valid`, and both counters are 0.
  - `req_ready=0`. It is registered and rises at the first edge after `rst` deasserts.
  - State is IDLE.
- **Latency:** request accepted at edge T gives `ce=1` during T→T+1, then L WAIT cycles. `rsp_valid` rises at edge T+1+L. With the defaults this is T+2 (non-multiply) or T+3 (multiply).
- **Back-to-back:** response handshake at edge R gives `req_ready=1` from R. The next request can be accepted at edge R+1, so the minimum period is L+3 cycles.
- **Backpressure:** `rsp_ready=0` holds RESP indefinitely. `ce` stays 0 and the counters are unchanged.
- **Reset mid-operation** (any state): immediately return to reset values. The in-flight operation is dropped and no response is produced.
- **Counter saturation:** at `16'hFFFF` a further completion leaves the value unchanged.

## Structure
- Package `alu_master_pkg` holds:
  - the state enum `alu_mst_state_e`;
  - the multiply command constants `CMD_MUL_INC=9` and `CMD_MUL_SHL=10`;
  - the flag bit indices `FLG_ERR=0` … `FLG_OFLOW=5`;
  - the function `cmd_latency(mode, cmd)`.
- One sub-module is natural: `alu_sat_cnt`, a 16-bit saturating counter with increment enable. It is instantiated twice.

## Test plan
- ADD: `mode=1`, `cmd=0`, `opa=8'h0F`, `opb=8'h01`, `inp_valid=2'b11`, tag 3, accepted at T.
  - `ce=1` only in cycle T→T+1.
  - ALU returns `9'h010`.
  - `rsp_valid` at T+2 with `rsp_res=9'h010` and `rsp_tag=3`.
- MUL: `mode=1`, `cmd=9`, `opa=3`, `opb=4`, `MUL_LAT=2`.
  - `rsp_valid` at T+3.
  - `opa`/`opb` stable through WAIT.
  - `rsp_res=9'h014`.
- Backpressure: hold `rsp_ready=0` for 5 cycles after `rsp_valid`.
  - `rsp_*` unchanged, `req_ready=0`, `ce=0`.
  - `op_count` increments only on the handshake.
- Error: `inp_valid=2'b00`.
  - ALU asserts `err`.
  - `rsp_flags=6'b000001`.
  - `err_count` goes 0→1 and `op_count` goes 0→1.
- Reset during WAIT of a multiply:
  - All outputs go to 0 asynchronously.
  - No `rsp_valid`.
  - Counters read 0.
  - `req_ready=1` one edge after release.
- Back-to-back: two ADDs with `rsp_ready` tied high.
  - The second is accepted exactly one edge after the first response handshake.
  - Tags are returned in order.
